// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and high time of one PWM line, in CLK cycles.
//
// The line is brought into the CLK domain by a 2-flop synchronizer. A rise is
// sig_s=1 while the previous sample was 0. The first rise after enable starts
// the measurement. Each later rise publishes the completed cycle on
// PERIOD/HIGH_TIME and pulses VALID for one cycle. The partial cycle in which
// the measurement started is never reported. If no rise is seen for
// TIMEOUT_CYC cycles, STUCK is set and STUCK_LVL records the line level.
// STUCK clears on the next VALID or when EN drops.
//
// Optional build macro PWM_CAPTURE_FILTER_EN adds a deglitcher between the
// synchronizer and the edge detector. The filtered level follows sig_s only
// after FILT_LEN consecutive samples of the new value.
//
// Ports:
//   CLK       in   system clock
//   RST       in   asynchronous active-high reset
//   PWM_IN    in   asynchronous PWM line
//   EN        in   measurement enable (level)
//   PERIOD    out  [CNT_W] last measured period
//   HIGH_TIME out  [CNT_W] last measured high time
//   VALID     out  one-cycle strobe, PERIOD/HIGH_TIME updated
//   STUCK     out  no rise within TIMEOUT_CYC cycles (level)
//   STUCK_LVL out  synchronized line level when STUCK was set
module pwm_capture #(
  parameter int CNT_W       = 24,
  parameter int TIMEOUT_CYC = 10000000,
  parameter int FILT_LEN    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PWM_IN,
  input  logic             EN,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic             VALID,
  output logic             STUCK,
  output logic             STUCK_LVL
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

  // Reject parameter sets the counters cannot represent.
  if (FILT_LEN < 1 || TIMEOUT_CYC < 1 ||
      longint'(TIMEOUT_CYC) >= (longint'(1) << CNT_W)) begin : g_bad_param
    $error("pwm_capture: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;

  // Counters stop at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic sync_p0, sync_p1;
  logic sig_s;
  logic line, line_d;
  logic rise;

  state_t           state, state_n;
  logic [CNT_W-1:0] per_cnt, per_cnt_n;
  logic [CNT_W-1:0] hi_cnt, hi_cnt_n;
  logic [CNT_W-1:0] period_n, high_n;
  logic             valid_n, stuck_n, stuck_lvl_n;

  // ---- stage p0/p1: synchronizer ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= PWM_IN;
      sync_p1 <= sync_p0;
    end
  end

  assign sig_s = sync_p1;

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);

  logic [FC_W-1:0] flt_cnt;
  logic            flt_lvl;

  // ---- deglitch stage ----
  // flt_cnt counts consecutive samples that differ from the accepted level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flt_cnt <= '0;
      flt_lvl <= 1'b0;
    end else if (sig_s == flt_lvl) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FC_W'(FILT_LEN - 1)) begin
      flt_lvl <= sig_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  assign line = flt_lvl;
`else
  assign line = sig_s;
`endif

  // ---- edge detect stage ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) line_d <= 1'b0;
    else     line_d <= line;
  end

  assign rise = line & ~line_d;

  // ---- measurement FSM / result registers ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      PERIOD    <= '0;
      HIGH_TIME <= '0;
      VALID     <= 1'b0;
      STUCK     <= 1'b0;
      STUCK_LVL <= 1'b0;
    end else begin
      state     <= state_n;
      per_cnt   <= per_cnt_n;
      hi_cnt    <= hi_cnt_n;
      PERIOD    <= period_n;
      HIGH_TIME <= high_n;
      VALID     <= valid_n;
      STUCK     <= stuck_n;
      STUCK_LVL <= stuck_lvl_n;
    end
  end

  always_comb begin
    state_n     = state;
    per_cnt_n   = per_cnt;
    hi_cnt_n    = hi_cnt;
    period_n    = PERIOD;
    high_n      = HIGH_TIME;
    valid_n     = 1'b0;
    stuck_n     = STUCK;
    stuck_lvl_n = STUCK_LVL;

    if (!EN) begin
      state_n   = IDLE;
      per_cnt_n = '0;
      hi_cnt_n  = '0;
      stuck_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n   = WAIT_RISE;
          per_cnt_n = '0;
          hi_cnt_n  = '0;
        end
        WAIT_RISE: begin
          // A rise wins over a timeout that lands in the same cycle.
          if (rise) begin
            per_cnt_n = CNT_W'(1);
            hi_cnt_n  = CNT_W'(1);
            state_n   = MEASURE;
          end else if (per_cnt == TIMEOUT_V) begin
            stuck_n     = 1'b1;
            stuck_lvl_n = line;
            per_cnt_n   = '0;
            hi_cnt_n    = '0;
          end else begin
            per_cnt_n = sat_inc(per_cnt);
          end
        end
        MEASURE: begin
          // The rise cycle itself is high, so a new cycle starts at 1/1.
          if (rise) begin
            period_n  = per_cnt;
            high_n    = hi_cnt;
            valid_n   = 1'b1;
            stuck_n   = 1'b0;
            per_cnt_n = CNT_W'(1);
            hi_cnt_n  = CNT_W'(1);
          end else if (per_cnt == TIMEOUT_V) begin
            stuck_n     = 1'b1;
            stuck_lvl_n = line;
            per_cnt_n   = '0;
            hi_cnt_n    = '0;
            state_n     = WAIT_RISE;
          end else begin
            per_cnt_n = sat_inc(per_cnt);
            if (line) hi_cnt_n = sat_inc(hi_cnt);
          end
        end
        default: begin
          state_n   = IDLE;
          per_cnt_n = '0;
          hi_cnt_n  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: randomized and directed PWM stimulus. Expected
// reports come from a cycle-level model of the line and are queued. A monitor
// pops and checks them on every VALID.
module tb_pwm_capture;

  localparam int CNT_W       = 24;
  localparam int TIMEOUT_CYC = 1000;
  localparam int FILT_LEN    = 4;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FLT = FILT_LEN;
`else
  localparam int FLT = 0;
`endif

  logic             CLK, RST, PWM_IN, EN;
  logic [CNT_W-1:0] PERIOD, HIGH_TIME;
  logic             VALID, STUCK, STUCK_LVL;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC), .FILT_LEN(FILT_LEN)) dut (
    .CLK(CLK), .RST(RST), .PWM_IN(PWM_IN), .EN(EN),
    .PERIOD(PERIOD), .HIGH_TIME(HIGH_TIME), .VALID(VALID),
    .STUCK(STUCK), .STUCK_LVL(STUCK_LVL)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int per;
    int hi;
    int at;
  } exp_t;

  exp_t q[$];
  int   cur_len  = 0;
  int   cur_high = 0;
  bit   armed    = 1'b0;
  bit   en_m     = 1'b0;
  bit   last_lvl = 1'b0;
  int   last_per = 0;
  int   last_hi  = 0;

  // A rise closes the cycle that started at the previous accepted rise,
  // provided measurement was armed and nothing interrupted it.
  task automatic model_rise();
    exp_t e;
    if (armed) begin
      e.per = cur_len;
      e.hi  = cur_high;
      e.at  = cyc + 3 + FLT;
      q.push_back(e);
      last_per = cur_len;
      last_hi  = cur_high;
    end
    armed    = en_m;
    cur_len  = 0;
    cur_high = 0;
  endtask

  // Drive PWM_IN at lvl for n cycles. With the filter, a segment shorter than
  // FILT_LEN is invisible, so the effective level stays as it was.
  task automatic seg(input bit lvl, input int n);
    bit eff;
    eff = lvl;
    if (FLT > 0 && n < FLT) eff = last_lvl;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      PWM_IN = lvl;
      if (i == 0) begin
        if (eff && !last_lvl) model_rise();
        last_lvl = eff;
      end
      cur_len++;
      if (eff) cur_high++;
      if (cur_len > TIMEOUT_CYC) armed = 1'b0;
    end
  endtask

  task automatic pwm(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      seg(1'b1, h);
      seg(1'b0, p - h);
    end
  endtask

  task automatic set_en(input bit v);
    EN    = v;
    en_m  = v;
    armed = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, 64'(PERIOD), 0);
    chk({tag, "_high"}, 64'(HIGH_TIME), 0);
    chk({tag, "_valid"}, 64'(VALID), 0);
    chk({tag, "_stuck"}, 64'(STUCK), 0);
    chk({tag, "_stuck_lvl"}, 64'(STUCK_LVL), 0);
  endtask

  // ---------------- monitor ----------------
  logic vld_prev = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (VALID === 1'b1) begin
      chk("valid_width", 64'(vld_prev), 0);
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: PERIOD %0d HIGH_TIME %0d, expected no VALID (cycle %0d)",
                 PERIOD, HIGH_TIME, cyc);
      end else begin
        e = q.pop_front();
        chk("period", 64'(PERIOD), 64'(e.per));
        chk("high_time", 64'(HIGH_TIME), 64'(e.hi));
        chk("valid_cycle", 64'(cyc), 64'(e.at));
      end
    end
    vld_prev = VALID;
  end

  // ---------------- stimulus ----------------
  initial begin
    int p, h;
    RST    = 1'b1;
    EN     = 1'b0;
    PWM_IN = 1'b0;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b0;

    // Disabled: a running PWM must never produce VALID.
    pwm(50, 20, 4);

    // Nominal.
    set_en(1'b1);
    pwm(100, 25, 5);

    // Duty extremes, switching mid-stream.
    pwm(10, 1, 5);
    pwm(10, 9, 5);

    // Random periods and duties.
    for (int i = 0; i < 30; i++) begin
      p = $urandom_range(200, 8);
      h = $urandom_range(p - 4, 4);
      pwm(p, h, 1);
    end

    // A period of exactly TIMEOUT_CYC: the rise and the timeout coincide.
    pwm(TIMEOUT_CYC, TIMEOUT_CYC / 2, 2);

    // Stuck high.
    seg(1'b1, 990);
    chk("stuck_hi_early", 64'(STUCK), 0);
    seg(1'b1, 30);
    chk("stuck_hi_set", 64'(STUCK), 1);
    chk("stuck_hi_lvl", 64'(STUCK_LVL), 1);
    chk("stuck_hi_period_hold", 64'(PERIOD), 64'(last_per));
    chk("stuck_hi_high_hold", 64'(HIGH_TIME), 64'(last_hi));
    seg(1'b0, 50);
    pwm(100, 40, 4);
    chk("stuck_hi_cleared", 64'(STUCK), 0);

    // Stuck low.
    seg(1'b1, 40);
    seg(1'b0, 900);
    chk("stuck_lo_early", 64'(STUCK), 0);
    seg(1'b0, 120);
    chk("stuck_lo_set", 64'(STUCK), 1);
    chk("stuck_lo_lvl", 64'(STUCK_LVL), 0);
    pwm(100, 40, 4);
    chk("stuck_lo_cleared", 64'(STUCK), 0);

    // EN dropped 40 cycles into a period, raised again 5 cycles later.
    pwm(100, 30, 3);
    seg(1'b1, 30);
    seg(1'b0, 10);
    set_en(1'b0);
    seg(1'b0, 5);
    set_en(1'b1);
    seg(1'b0, 55);
    pwm(100, 30, 4);

    // A 2-cycle low glitch inside the high phase.
    for (int i = 0; i < 3; i++) begin
      seg(1'b1, 20);
      seg(1'b0, 2);
      seg(1'b1, 28);
      seg(1'b0, 50);
    end

    // Asynchronous reset in the middle of a period.
    seg(1'b1, 30);
    seg(1'b0, 10);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 chk_zero("midreset");
    repeat (3) @(negedge CLK);
    RST      = 1'b0;
    armed    = 1'b0;
    cur_len  = 0;
    cur_high = 0;
    seg(1'b0, 60);
    pwm(100, 35, 3);
    seg(1'b1, 10);
    seg(1'b0, 30);

    chk("queue_drained", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the board PWM drivers (buzzer/RGB LED channels).
- Samples one external or looped-back PWM line and measures its period and high time in CLK cycles.
- Reports each completed cycle with a one-cycle VALID strobe, and flags a line stuck high or low.
- Sits in the partial-reconfiguration region beside the PWM generators, for self-test and for closed-loop duty checking.

Parameters:
- CNT_W, 24, width of the period/high-time counters and result registers.
- TIMEOUT_CYC, 10000000, cycles since the last accepted rising edge before STUCK asserts; must be < 2^CNT_W.
- FILT_LEN, 4, stable-sample count for the glitch filter; only used when PWM_CAPTURE_FILTER_EN is defined.

Ports:
- CLK, input, 1, system clock.
- RST, input, 1, asynchronous active-high reset.
- PWM_IN, input, 1, asynchronous PWM line to measure.
- EN, input, 1, measurement enable (level).
- PERIOD, output, CNT_W, last measured period in CLK cycles.
- HIGH_TIME, output, CNT_W, last measured high time in CLK cycles.
- VALID, output, 1, one-cycle strobe; PERIOD/HIGH_TIME updated this cycle.
- STUCK, output, 1, no rising edge within TIMEOUT_CYC (level).
- STUCK_LVL, output, 1, synchronized line level when STUCK was set.

Behaviour:
- Reset (async, active-high): state IDLE; synchronizer flops 0; all counters 0; PERIOD=0, HIGH_TIME=0, VALID=0, STUCK=0, STUCK_LVL=0.
- Input path: PWM_IN goes through a 2-flop synchronizer (sig_s), then an edge detector against the previous sig_s.
- A rise is sig_s=1 with previous=0.
- States:
  - IDLE: counters held at 0. Go to WAIT_RISE when EN=1.
  - WAIT_RISE: waits for the first rise. On rise: period_cnt=1; high_cnt=1; go to MEASURE. The partial first cycle is never reported.
  - MEASURE: period_cnt increments every cycle; high_cnt increments on each cycle with sig_s=1.
    - On rise: PERIOD<=period_cnt, HIGH_TIME<=high_cnt, VALID=1 for exactly that cycle, STUCK<=0.
    - Counters then restart at 1, as in WAIT_RISE.
- Accuracy: for a stable input with period P and high time H cycles (P>=2, 1<=H<=P-1), reported PERIOD=P and HIGH_TIME=H exactly.
- Latency: VALID rises 3 CLK after the PWM_IN rising edge is first sampled (2 sync + 1 register). The first VALID follows the second rising edge after EN.
- Counters saturate at 2^CNT_W-1; they never wrap.
- Timeout (WAIT_RISE or MEASURE): when period_cnt reaches TIMEOUT_CYC with no rise:
  - STUCK<=1 and STUCK_LVL<=sig_s; go to WAIT_RISE.
  - PERIOD and HIGH_TIME hold their last values; no VALID.
  - STUCK stays set until the next VALID or EN=0.
- Rise and timeout in the same cycle: the rise wins (capture and VALID, STUCK not set).
- EN deasserted in any state: next state IDLE, counters cleared, STUCK cleared, VALID=0. PERIOD and HIGH_TIME hold.
- Reset mid-measurement: immediate return to reset values; no VALID is generated.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined:
  - sig_s passes through a deglitcher before edge detection. The filtered level changes only after sig_s holds the new value for FILT_LEN consecutive cycles.
  - Pulses or gaps shorter than FILT_LEN cycles are ignored.
  - Latency grows to 3+FILT_LEN CLK. Measured P and H are unchanged for pulses >= FILT_LEN.
- Undefined: no filter logic; the edge detector uses sig_s directly; latency is 3 CLK.

Test Plan:
- Reset and idle: assert RST mid-run with EN=1 and a toggling input -> all outputs 0 immediately. With EN=0 and a 50-cycle PWM -> VALID never asserts.
- Nominal: EN=1, PWM P=100, H=25 -> first VALID 3 cycles after the 2nd rise; PERIOD=100, HIGH_TIME=25; VALID repeats every 100 cycles, 1 cycle wide.
- Duty extremes: P=10 with H=1, then H=9 -> HIGH_TIME=1 and 9, PERIOD=10 each. Switch from H=1 to H=9 mid-stream -> first post-switch report is exact, with no spurious VALID.
- Stuck line: TIMEOUT_CYC=1000; drive PWM_IN constant 1 after a rise -> STUCK=1 and STUCK_LVL=1 at 1000 cycles after the last accepted rise; PERIOD holds.
  - Restore a PWM of P=100 -> STUCK clears on the first VALID.
  - Repeat with constant 0 -> STUCK_LVL=0.
- EN toggle: drop EN at cycle 40 of a 100-cycle period, re-raise 5 cycles later -> no VALID for the interrupted period; next VALID comes after two further rises with PERIOD=100.
- Filter (PWM_CAPTURE_FILTER_EN, FILT_LEN=4): P=100, H=50 with a 2-cycle low glitch inside the high phase -> PERIOD=100, HIGH_TIME=50, no extra VALID.
  - Without the macro, the same stimulus yields an extra VALID with a shortened PERIOD.
